// File: rtl/operand_feeder.sv
// Operand feeder for a 4x4 systolic array: stores A and B, then
// streams them as skewed diagonal waves with a fixed step period.
module operand_feeder #(
  parameter int STEP_PERIOD = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        wr_sel,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic        feed_ready,
  output logic [3:0]  wave_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(STEP_PERIOD - 2);
  localparam logic [3:0] K_LAST    = 4'd9;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q [16];
  logic [7:0]  b_q [16];
  logic [31:0] a_wave;
  logic [31:0] b_wave;
  logic        wave_act;

  // Sequencer state, wave index and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand storage; loads only accepted while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < 16; e++) begin
        a_q[e] <= '0;
        b_q[e] <= '0;
      end
    end else if (wr_en && (state_q == IDLE)) begin
      if (wr_sel) begin
        b_q[wr_addr] <= wr_data;
      end else begin
        a_q[wr_addr] <= wr_data;
      end
    end
  end

  // Next-state: one issue cycle, STEP_PERIOD-1 wait cycles per wave
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          if (k_q == K_LAST) begin
            state_d = FINISH;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Diagonal wave selection: row i takes A[i][k-i], col j takes B[k-j][j]
  always_comb begin
    a_wave = '0;
    b_wave = '0;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = int'(k_q) - i;
      if ((d >= 0) && (d <= 3)) begin
        a_wave[i*8 +: 8] = a_q[4'(i*4 + d)];
        b_wave[i*8 +: 8] = b_q[4'(d*4 + i)];
      end
    end
  end

  // Outputs decoded from state; lanes held through the wait window
  always_comb begin
    wave_act   = (state_q == ISSUE) || (state_q == WAIT);
    a_out      = wave_act ? a_wave : '0;
    b_out      = wave_act ? b_wave : '0;
    wave_idx   = k_q;
    feed_ready = (state_q == ISSUE);
    busy       = (state_q != IDLE);
    done       = (state_q == FINISH);
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: two instances (period 12 and 15)
// driven identically, checked against a scoreboard of expected waves.
module tb_operand_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        start = 1'b0;

  logic [31:0] ao [2];
  logic [31:0] bo [2];
  logic        fr [2];
  logic        bz [2];
  logic        dn [2];
  logic [3:0]  wi [2];

  operand_feeder #(.STEP_PERIOD(12)) u12 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .a_out(ao[0]), .b_out(bo[0]), .feed_ready(fr[0]),
    .wave_idx(wi[0]), .busy(bz[0]), .done(dn[0])
  );

  operand_feeder #(.STEP_PERIOD(15)) u15 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
    .a_out(ao[1]), .b_out(bo[1]), .feed_ready(fr[1]),
    .wave_idx(wi[1]), .busy(bz[1]), .done(dn[1])
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  k;
  } exp_t;

  exp_t        q [2][$];
  int          per [2] = '{12, 15};
  int          es [2];
  int          ed [2];
  bit          act [2];
  logic [31:0] la [2];
  logic [31:0] lb [2];
  logic [7:0]  ma [16];
  logic [7:0]  mb [16];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          chk31 = 1'b0;
  bit          chk32 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] wave_a(input int k);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = k - i;
      if (d >= 0 && d <= 3) r[i*8 +: 8] = ma[i*4 + d];
    end
    return r;
  endfunction

  function automatic logic [31:0] wave_b(input int k);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      int d;
      d = k - j;
      if (d >= 0 && d <= 3) r[j*8 +: 8] = mb[d*4 + j];
    end
    return r;
  endfunction

  task automatic model_wr(input bit sel, input int addr, input logic [7:0] d);
    if (sel) mb[addr] = d;
    else ma[addr] = d;
  endtask

  task automatic push_stream();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b1;
      es[i]  = cyc;
      ed[i]  = cyc + 10 * per[i];
      la[i]  = '0;
      lb[i]  = '0;
      for (int n = 0; n < 10; n++) begin
        e.cyc = cyc + n * per[i];
        e.a   = wave_a(n);
        e.b   = wave_b(n);
        e.k   = 4'(n);
        q[i].push_back(e);
      end
    end
  endtask

  task automatic write(input bit sel, input int addr, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model_wr(sel, addr, d);
  endtask

  // Start pulse, optionally with a same-edge write; acc = expected to be taken
  task automatic kick(input bit wr, input bit sel, input int addr,
                      input logic [7:0] d, input bit acc);
    @(negedge clk);
    start = 1'b1;
    wr_en = wr;
    wr_sel = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    if (acc) begin
      if (wr) model_wr(sel, addr, d);
      push_stream();
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (!act[0] && !act[1]) break;
    end
    checks++;
    assert (!act[0] && !act[1]) else begin
      errors++;
      $error("FAIL stream_end act=%0b%0b required=00", act[0], act[1]);
    end
  endtask

  task automatic wait_cyc(input int t);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cyc >= t) break;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      checks++;
      assert (ao[i] === 32'h0 && bo[i] === 32'h0 && fr[i] === 1'b0 &&
              bz[i] === 1'b0 && dn[i] === 1'b0) else begin
        errors++;
        $error("FAIL %s inst=%0d a=%h b=%h fr=%b busy=%b done=%b required=0",
               tag, i, ao[i], bo[i], fr[i], bz[i], dn[i]);
      end
    end
  endtask

  // Cycle monitor: pops the scoreboard on every feed and checks holds
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        exp_t e;
        bit   bexp;
        checks++;
        assert (!(fr[i] && dn[i])) else begin
          errors++;
          $error("FAIL overlap inst=%0d fr=%b done=%b required=not both", i, fr[i], dn[i]);
        end
        bexp = act[i] && cyc >= es[i] && cyc <= ed[i];
        checks++;
        assert (bz[i] === bexp) else begin
          errors++;
          $error("FAIL busy inst=%0d cyc=%0d got=%b required=%b", i, cyc, bz[i], bexp);
        end
        if (q[i].size() > 0 && !fr[i] && cyc > q[i][0].cyc) begin
          e = q[i].pop_front();
          checks++;
          errors++;
          $error("FAIL missed_feed inst=%0d k=%0d got=none required=cyc %0d", i, e.k, e.cyc);
        end
        if (fr[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $error("FAIL stray_feed inst=%0d cyc=%0d got=1 required=0", i, cyc);
          end else begin
            e = q[i].pop_front();
            la[i] = e.a;
            lb[i] = e.b;
            assert (cyc == e.cyc && ao[i] === e.a && bo[i] === e.b && wi[i] === e.k)
            else begin
              errors++;
              $error("FAIL wave inst=%0d got cyc=%0d k=%0d a=%h b=%h required cyc=%0d k=%0d a=%h b=%h",
                     i, cyc, wi[i], ao[i], bo[i], e.cyc, e.k, e.a, e.b);
            end
          end
          if (i == 0 && chk31 && wi[0] == 4'd3) begin
            checks++;
            assert (ao[0] === 32'h0 && bo[0] === 32'h04070A0D) else begin
              errors++;
              $error("FAIL wave3 got a=%h b=%h required a=00000000 b=04070a0d", ao[0], bo[0]);
            end
          end
          if (i == 0 && chk32 && wi[0] == 4'd0) begin
            checks++;
            assert (ao[0] === 32'h00000080) else begin
              errors++;
              $error("FAIL neg_wave0 got a=%h required a=00000080", ao[0]);
            end
          end
        end else begin
          logic [31:0] xa, xb;
          xa = (act[i] && cyc < ed[i]) ? la[i] : 32'h0;
          xb = (act[i] && cyc < ed[i]) ? lb[i] : 32'h0;
          checks++;
          assert (ao[i] === xa && bo[i] === xb) else begin
            errors++;
            $error("FAIL hold inst=%0d cyc=%0d got a=%h b=%h required a=%h b=%h",
                   i, cyc, ao[i], bo[i], xa, xb);
          end
        end
        if (dn[i]) begin
          checks++;
          assert (act[i] && cyc == ed[i]) else begin
            errors++;
            $error("FAIL done inst=%0d got cyc=%0d required cyc=%0d act=%b", i, cyc, ed[i], act[i]);
          end
          act[i] = 1'b0;
        end else if (act[i] && cyc > ed[i]) begin
          checks++;
          errors++;
          $error("FAIL done_missing inst=%0d got=none required=cyc %0d", i, ed[i]);
          act[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    for (int e = 0; e < 16; e++) begin
      ma[e] = '0;
      mb[e] = '0;
    end
    act[0] = 1'b0;
    act[1] = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    check_zero("reset_async");
    for (int i = 0; i < 2; i++) begin
      checks++;
      assert (wi[i] === 4'd0) else begin
        errors++;
        $error("FAIL reset_idx inst=%0d got=%0d required=0", i, wi[i]);
      end
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Stream 1: A = identity, B[r][c] = r*4+c+1
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        write(1'b0, r*4 + c, (r == c) ? 8'd1 : 8'd0);
        write(1'b1, r*4 + c, 8'(r*4 + c + 1));
      end
    end
    chk31 = 1'b1;
    kick(1'b0, 1'b0, 0, 8'd0, 1'b1);
    wait_idle();
    chk31 = 1'b0;

    // Stream 2: A[0][0] = -128 with start; stray start/write at k=4
    chk32 = 1'b1;
    kick(1'b1, 1'b0, 0, 8'h80, 1'b1);
    wait_cyc(es[0] + 4 * per[0] + 2);
    chk32 = 1'b0;
    kick(1'b1, 1'b0, 5, 8'd5, 1'b0);
    wait_idle();

    // Stream 3: A[1][1] must still be 1; reset between edges at k=5
    kick(1'b0, 1'b0, 0, 8'd0, 1'b1);
    wait_cyc(es[0] + 5 * per[0] + 3);
    #2;
    rst = 1'b1;
    act[0] = 1'b0;
    act[1] = 1'b0;
    q[0].delete();
    q[1].delete();
    for (int e = 0; e < 16; e++) begin
      ma[e] = '0;
      mb[e] = '0;
    end
    #1;
    check_zero("reset_abort");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (20) @(posedge clk);

    // Stream 4: storage cleared by reset, all-zero waves
    kick(1'b0, 1'b0, 0, 8'd0, 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter STEP_PERIOD, default 12, sets the cycles between consecutive feed_ready pulses (legal range 12..15).
REQ-002 Port clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port wr_en  input  1  load strobe for one operand element.
REQ-005 Port wr_sel  input  1  target matrix: 0 = A, 1 = B.
REQ-006 Port wr_addr  input  4  element index = row*4 + col.
REQ-007 Port wr_data  input  8  signed element value.
REQ-008 Port start  input  1  single-cycle request to stream both matrices.
REQ-009 Port a_out  output  32  A lanes for array rows 0..3; lane i = bits [8i+7:8i].
REQ-010 Port b_out  output  32  B lanes for array columns 0..3; lane j = bits [8j+7:8j].
REQ-011 Port feed_ready  output  1  one-cycle pulse marking a valid wave on a_out/b_out.
REQ-012 Port wave_idx  output  4  index k of the wave currently held on a_out/b_out.
REQ-013 Port busy  output  1  high from the cycle after start is accepted until done.
REQ-014 Port done  output  1  one-cycle pulse at end of stream.

Function
REQ-015 Storage SHALL be two 4x4 arrays of signed 8-bit values, A and B.
REQ-016 A write SHALL occur on a clock edge with wr_en=1 and busy=0; writes while busy=1 SHALL be ignored.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, FINISH.
REQ-018 IDLE: start=1 SHALL set k=0, busy=1 and move to ISSUE; start while not IDLE SHALL be ignored.
REQ-019 ISSUE (one cycle): a_out lane i = A[i][k-i] when 0<=k-i<=3, else 0; b_out lane j = B[k-j][j] when 0<=k-j<=3, else 0; feed_ready=1; wave_idx=k; next state WAIT.
REQ-020 Waves k=7..9 SHALL be all-zero drain waves; a stream SHALL contain exactly 10 waves (k=0..9).
REQ-021 WAIT SHALL last STEP_PERIOD-1 cycles, with feed_ready=0 and a_out/b_out/wave_idx held.
REQ-022 At the end of WAIT: if k<9, increment k and go to ISSUE; if k=9, go to FINISH.
REQ-023 FINISH (one cycle): done=1, busy=0 from the next cycle, a_out/b_out cleared to 0, then IDLE.
REQ-024 Timing: start sampled at edge T; feed_ready high during cycle T+1+n*STEP_PERIOD for n=0..9; done high during cycle T+1+10*STEP_PERIOD.
REQ-025 A write and start on the same edge in IDLE SHALL both take effect; wave 0 SHALL use the updated element.
REQ-026 feed_ready and done SHALL never be high in the same cycle.
REQ-027 Lane values SHALL be passed through unmodified, with no sign or width changes.

Reset
REQ-028 While rst=1, regardless of clk: state=IDLE, k=0, A and B all zero, a_out=0, b_out=0, wave_idx=0, feed_ready=0, busy=0, done=0.
REQ-029 Reset asserted mid-stream SHALL abort the stream immediately, with no done pulse; after release the block SHALL sit in IDLE awaiting start.

Verification
REQ-030 Load A=I (identity), B[r][c]=r*4+c+1, start, STEP_PERIOD=12 -> feed_ready at T+1, T+13, ..., T+109; done at T+121; busy high T+1..T+121.
REQ-031 Same load, check wave k=3 -> a_out lanes {A[0][3],A[1][2],A[2][1],A[3][0]} = {0,0,0,0}; b_out lanes {B[3][0],B[2][1],B[1][2],B[0][3]} = {13,10,7,4}.
REQ-032 Write A[0][0]=-128 (0x80) with start on the same edge -> wave 0 a_out lane 0 = 0x80; other lanes 0.
REQ-033 Pulse start and wr_en (A[1][1]=5) at k=4 mid-stream -> stream unchanged, 10 waves total, A[1][1] keeps its old value.
REQ-034 Assert rst between clock edges at k=5 -> outputs 0 immediately; no further feed_ready, no done; a fresh start after release yields all-zero waves.
REQ-035 STEP_PERIOD=15 -> feed_ready spacing 15 cycles; done at T+151.
